// File: rtl/alu_pkg.sv
// Shared types for the integer execute path: ALU opcodes, the NZCV flag
// layout and the branch condition codes with their evaluation rule.
package alu_pkg;

  localparam int FLAGS_W = 4;
  localparam int COND_W  = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_SLL = 3'd3,
    OP_SRL = 3'd4
  } alu_op_e;

  // Field order matches the in_flags bus: bit3=N ... bit0=V.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [COND_W-1:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_CS = 3'b101,
    COND_CC = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  function automatic logic cond_true(input cond_e cond, input flags_t f);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = f.z;
      COND_NE: taken = !f.z;
      COND_LT: taken = f.n ^ f.v;
      COND_GE: taken = !(f.n ^ f.v);
      COND_CS: taken = f.c;
      COND_CC: taken = !f.c;
      COND_NV: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ex_result_stage_if.sv
// Upstream (ALU issue) and downstream (writeback) handshake bundle of the
// execute result stage. The stage itself uses the slave view.
interface ex_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_result;
  logic [FLAGS_W-1:0]  in_flags;
  logic                in_set_flags;
  logic                in_wr_en;
  logic [RD_W-1:0]     in_rd;
  logic                in_is_branch;
  logic [COND_W-1:0]   in_cond;
  logic [DATA_W-1:0]   in_target;

  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_result;
  logic                out_wr_en;
  logic [RD_W-1:0]     out_rd;

  modport slave (
    input  in_valid, in_result, in_flags, in_set_flags, in_wr_en, in_rd,
           in_is_branch, in_cond, in_target, out_ready,
    output in_ready, out_valid, out_result, out_wr_en, out_rd
  );

  modport master (
    output in_valid, in_result, in_flags, in_set_flags, in_wr_en, in_rd,
           in_is_branch, in_cond, in_target, out_ready,
    input  in_ready, out_valid, out_result, out_wr_en, out_rd
  );

endinterface

// File: rtl/ex_result_stage_fifo.sv
// Writeback buffer: DEPTH entries of {result, wr_en, rd} with wrapping
// pointers, an occupancy counter and a synchronous flush.
module stage_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_result,
  input  logic              push_wr_en,
  input  logic [RD_W-1:0]   push_rd,
  output logic [DATA_W-1:0] head_result,
  output logic              head_wr_en,
  output logic [RD_W-1:0]   head_rd,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] result_mem [DEPTH];
  logic              wr_en_mem  [DEPTH];
  logic [RD_W-1:0]   rd_mem     [DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // Flush wins over both sides of the handshake in the same cycle.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        result_mem[i] <= '0;
        wr_en_mem[i]  <= 1'b0;
        rd_mem[i]     <= '0;
      end
    end else if (do_push) begin
      result_mem[wr_ptr] <= push_result;
      wr_en_mem[wr_ptr]  <= push_wr_en;
      rd_mem[wr_ptr]     <= push_rd;
    end
  end

  assign head_result = result_mem[rd_ptr];
  assign head_wr_en  = wr_en_mem[rd_ptr];
  assign head_rd     = rd_mem[rd_ptr];

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(pop && empty));

endmodule

// File: rtl/ex_result_stage.sv
// Execute result stage: owns the NZCV register, resolves conditional branches
// against it and buffers completed operations for register writeback.
module ex_result_stage
  import alu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_result_stage_if.slave  bus,
  output flags_t            flags_q,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  logic push;
  logic pop;
  logic full;
  logic empty;
  logic branch_taken;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // in_ready depends only on the occupancy register, never on out_ready.
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  stage_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .RD_W   (RD_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push        (push),
    .pop         (pop),
    .push_result (bus.in_result),
    .push_wr_en  (bus.in_wr_en),
    .push_rd     (bus.in_rd),
    .head_result (bus.out_result),
    .head_wr_en  (bus.out_wr_en),
    .head_rd     (bus.out_rd),
    .full        (full),
    .empty       (empty)
  );

  // Branches see flags_q from before this edge, never their own flag update.
  assign branch_taken = push && bus.in_is_branch &&
                        cond_true(cond_e'(bus.in_cond), flags_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (push && bus.in_set_flags) begin
      flags_q <= flags_t'(bus.in_flags);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= branch_taken;
      if (branch_taken) redirect_pc <= bus.in_target;
    end
  end

endmodule

// File: doc/ex_result_stage.md
Name: ex_result_stage

Overview:
- Sits directly downstream of the integer ALU and consumes its result and its carry/zero/negative/overflow flags.
- Holds the architectural NZCV flag register and resolves conditional branches against it.
- Buffers completed operations in a small FIFO with valid/ready handshakes on both sides, feeding the register-file writeback port.
- Decouples ALU issue from writeback stalls.

Parameters:
- DEPTH, 2, number of buffer entries (power of two, >=2).
- DATA_W, 32, width of result and branch target.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- flush  in  1  synchronous clear of the buffer contents.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  DATA_W  ALU result.
- in_flags  in  4  ALU flags {N,Z,C,V}, bit3=N, bit0=V.
- in_set_flags  in  1  entry updates the flag register.
- in_wr_en  in  1  entry writes rd.
- in_rd  in  RD_W  destination register.
- in_is_branch  in  1  entry is a conditional branch.
- in_cond  in  3  branch condition code.
- in_target  in  DATA_W  branch target address.
- out_valid  out  1  head entry present.
- out_ready  in  1  writeback accepts head.
- out_result  out  DATA_W  head result.
- out_wr_en  out  1  head write enable.
- out_rd  out  RD_W  head destination.
- flags_q  out  4  architectural NZCV register.
- redirect_valid  out  1  one-cycle pulse, taken branch.
- redirect_pc  out  DATA_W  redirect address.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - count=0, out_valid=0, in_ready=1.
  - flags_q=0, redirect_valid=0, redirect_pc=0.
  - out_result/out_wr_en/out_rd=0.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != DEPTH), derived from registers only; there is no combinational path from out_ready.
  - out_* reflect the head entry combinationally from storage.
  - out_valid = (count != 0).
- Simultaneous push and pop:
  - count unchanged; pointers both advance.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle (one bubble is accepted).
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1.
- Flag register:
  - On push with in_set_flags=1, flags_q <= in_flags at that edge.
  - Otherwise flags_q holds.
  - flush does not affect flags_q.
- Branch resolution, on push with in_is_branch=1:
  - The condition is evaluated against flags_q as registered before this edge, so an entry never sees its own flags.
  - A flag-setter pushed in cycle N is visible to a branch pushed in cycle N+1.
  - Condition codes:
    - 000 always.
    - 001 EQ (Z).
    - 010 NE (!Z).
    - 011 LT (N^V).
    - 100 GE (!(N^V)).
    - 101 CS (C).
    - 110 CC (!C).
    - 111 never.
  - Taken: redirect_valid=1 for exactly the next cycle and redirect_pc <= in_target.
  - Not taken: redirect_valid=0.
  - redirect_pc holds its last value otherwise.
- Branch entries are still pushed to the buffer; their in_wr_en is passed through unchanged.
- flush=1:
  - count and pointers return to 0 at the edge.
  - A push in the same cycle is discarded, but its flag update and redirect still take effect.
  - A pop in the same cycle is ignored.
- rst_n asserted mid-operation: all state returns immediately to reset values. The in-flight redirect pulse is cancelled.
- Upstream flushes itself on redirect_valid; this block never drops entries except on flush.
- Arithmetic: count is log2(DEPTH)+1 bits. No overflow or underflow is possible by construction; an assertion must flag a push when full or a pop when empty.

Decomposition:
- alu_pkg holds:
  - the 3-bit ALU opcode enum (ADD, SUB, AND, SLL, SRL).
  - flags_t packed struct {n,z,c,v}.
  - the 3-bit cond_e enum with the encodings above.
  - function cond_true(cond_e, flags_t) returning the taken decision.
- One sub-module is natural: stage_fifo (DEPTH x {result, wr_en, rd}, count, pointers, flush).
- The flag register, branch resolution and redirect logic live in ex_result_stage.

Test Plan:
- Reset, then push result=0x0000_0005, wr_en=1, rd=3 with out_ready=1 -> out_valid=1 next cycle with out_result=5, out_rd=3; empty after the pop.
- Hold out_ready=0 and push 3 entries (0xA, 0xB, 0xC) -> in_ready drops after 2 accepted. Release out_ready -> out_result sequence 0xA, 0xB; 0xC is accepted only after in_ready returns.
- SUB flag-setter with in_flags=0100 (Z) pushed in cycle N, then branch EQ with target 0x100 in cycle N+1 -> redirect_valid pulses for one cycle with redirect_pc=0x100, and flags_q=0100.
- Branch EQ pushed in the same cycle that flags_q=0000 while carrying in_set_flags=1, in_flags=0100 -> not taken (its own flags are ignored), and flags_q becomes 0100 afterwards.
- Buffer holds 2 entries; assert flush with a concurrent push of a flag-setter with in_flags=1000 -> count=0, out_valid=0, flags_q=1000.
- Drop rst_n asynchronously mid-pulse while redirect_valid=1 and count=1 -> redirect_valid, out_valid and flags_q are 0 immediately, and in_ready=1.
